// File: rtl/sr_pulse_ctrl.sv
// sr_pulse_ctrl: button front-end for a NOR SR latch.
// Each raw button is synchronized, debounced and turned into a fixed-width
// pulse on s or r. A small FSM serializes the pulses, inserts a one-cycle
// gap between them, keeps one pending request and flags same-cycle conflicts
// (reset wins). s and r are registered and are never high together.
module sr_pulse_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PULSE_CYCLES    = 2,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic rst_btn,
  input  logic conflict_clr,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE_S = 2'd1,
    ST_PULSE_R = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  // Channel index 0 = set button, 1 = reset button.
  logic [1:0]       sync1_r;
  logic [1:0]       sync2_r;
  logic [1:0]       deb_r;
  logic [1:0]       req_r;
  logic [CNT_W-1:0] deb_cnt_r [2];

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] pcnt_r;
  logic [CNT_W-1:0] pcnt_s;
  logic             pend_v_r;
  logic             pend_v_s;
  logic             pend_is_r_r;
  logic             pend_is_r_s;
  logic             conflict_r;
  logic             conflict_s;
  logic             s_r;
  logic             r_r;
  logic             busy_r;

  logic             req_any_s;
  logic             req_is_r_s;
  logic             req_both_s;

  // Two-flop synchronizer for both raw buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
    end else begin
      sync1_r <= {rst_btn, set_btn};
      sync2_r <= sync1_r;
    end
  end

  // Debounce each channel; emit a one-cycle request on a debounced rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_r        <= 2'b00;
      req_r        <= 2'b00;
      deb_cnt_r[0] <= '0;
      deb_cnt_r[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          deb_cnt_r[i] <= '0;
          req_r[i]     <= 1'b0;
        end else if (deb_cnt_r[i] == DEB_LAST) begin
          deb_r[i]     <= ~deb_r[i];
          deb_cnt_r[i] <= '0;
          // Only the 0->1 direction is a request; a release is silent.
          req_r[i]     <= ~deb_r[i];
        end else begin
          deb_cnt_r[i] <= deb_cnt_r[i] + CNT_ONE;
          req_r[i]     <= 1'b0;
        end
      end
    end
  end

  // Request decode: any request, reset priority, and same-cycle conflict.
  always_comb begin
    req_any_s  = req_r[0] | req_r[1];
    req_is_r_s = req_r[1];
    req_both_s = req_r[0] & req_r[1];
  end

  // Next-state, pulse counter, pending slot and conflict flag.
  always_comb begin
    state_s     = state_r;
    pcnt_s      = pcnt_r;
    pend_v_s    = pend_v_r;
    pend_is_r_s = pend_is_r_r;
    conflict_s  = conflict_r;

    case (state_r)
      ST_IDLE: begin
        if (req_any_s) begin
          state_s = req_is_r_s ? ST_PULSE_R : ST_PULSE_S;
          pcnt_s  = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PULSE_S, ST_PULSE_R: begin
        if (pcnt_r == PULSE_LAST) begin
          state_s = ST_GAP;
          pcnt_s  = '0;
        end else begin
          pcnt_s  = pcnt_r + CNT_ONE;
        end
        // Requests during a pulse are parked; the newest one wins.
        if (req_any_s) begin
          pend_v_s    = 1'b1;
          pend_is_r_s = req_is_r_s;
        end else begin
          pend_v_s    = pend_v_r;
        end
      end
      ST_GAP: begin
        // A request arriving in the gap overwrites the slot and is
        // consumed by the same decision, so nothing is stranded in IDLE.
        if (req_any_s) begin
          state_s  = req_is_r_s ? ST_PULSE_R : ST_PULSE_S;
          pcnt_s   = '0;
          pend_v_s = 1'b0;
        end else if (pend_v_r) begin
          state_s  = pend_is_r_r ? ST_PULSE_R : ST_PULSE_S;
          pcnt_s   = '0;
          pend_v_s = 1'b0;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        pcnt_s   = '0;
        pend_v_s = 1'b0;
      end
    endcase

    // Setting the flag beats a same-cycle clear.
    if (req_both_s) begin
      conflict_s = 1'b1;
    end else if (conflict_clr) begin
      conflict_s = 1'b0;
    end else begin
      conflict_s = conflict_r;
    end
  end

  // State registers and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      pcnt_r      <= '0;
      pend_v_r    <= 1'b0;
      pend_is_r_r <= 1'b0;
      conflict_r  <= 1'b0;
      s_r         <= 1'b0;
      r_r         <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      pcnt_r      <= pcnt_s;
      pend_v_r    <= pend_v_s;
      pend_is_r_r <= pend_is_r_s;
      conflict_r  <= conflict_s;
      s_r         <= (state_s == ST_PULSE_S);
      r_r         <= (state_s == ST_PULSE_R);
      busy_r      <= (state_s != ST_IDLE) | pend_v_s;
    end
  end

  assign s        = s_r;
  assign r        = r_r;
  assign busy     = busy_r;
  assign conflict = conflict_r;

endmodule

// File: tb/tb_sr_pulse_ctrl.sv
// Self-checking bench for sr_pulse_ctrl: a timeline reference model predicts
// each pulse (kind and start edge) into a queue; a negedge monitor pops and
// compares whenever s or r rises, and checks busy/conflict every cycle.
module tb_sr_pulse_ctrl;

  localparam int D = 4;
  localparam int P = 2;

  logic clk          = 1'b0;
  logic rst_n        = 1'b0;
  logic set_btn      = 1'b0;
  logic rst_btn      = 1'b0;
  logic conflict_clr = 1'b0;
  logic s;
  logic r;
  logic busy;
  logic conflict;

  sr_pulse_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .PULSE_CYCLES   (P),
    .CNT_W          (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_btn     (set_btn),
    .rst_btn     (rst_btn),
    .conflict_clr(conflict_clr),
    .s           (s),
    .r           (r),
    .busy        (busy),
    .conflict    (conflict)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit is_r;
    int start;
  } pulse_t;

  pulse_t exp_q[$];

  // Reference model state.
  int cyc        = 0;
  int rst_events = 0;
  bit m_ff1[2];
  bit m_ff2[2];
  bit m_deb[2];
  bit m_req[2];
  int m_run[2];
  int m_end  = 0;   // first edge at which the model is free again
  bit m_pv   = 1'b0;
  bit m_pr   = 1'b0;
  bit m_conf = 1'b0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: advances one clock edge at a time.
  always @(posedge clk) begin
    bit has;
    bit kind;
    bit both;
    bit in_now[2];
    cyc++;
    in_now[0] = set_btn;
    in_now[1] = rst_btn;
    if (!rst_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        m_ff1[ch] = 1'b0;
        m_ff2[ch] = 1'b0;
        m_deb[ch] = 1'b0;
        m_req[ch] = 1'b0;
        m_run[ch] = 0;
      end
      m_end  = 0;
      m_pv   = 1'b0;
      m_pr   = 1'b0;
      m_conf = 1'b0;
      rst_events++;
    end else begin
      has  = m_req[0] || m_req[1];
      kind = m_req[1];
      both = m_req[0] && m_req[1];
      if (cyc < m_end) begin
        if (has) begin
          m_pv = 1'b1;
          m_pr = kind;
        end
      end else begin
        if (!has && m_pv) begin
          has  = 1'b1;
          kind = m_pr;
        end
        m_pv = 1'b0;
        if (has) begin
          m_end = cyc + P + 1;  // P pulse cycles plus one gap cycle
          exp_q.push_back('{is_r: kind, start: cyc});
        end
      end
      if (both) m_conf = 1'b1;
      else if (conflict_clr) m_conf = 1'b0;
      // Debounce: toggle once ff2 has differed for D consecutive samples.
      for (int ch = 0; ch < 2; ch++) begin
        m_req[ch] = 1'b0;
        if (m_ff2[ch] == m_deb[ch]) begin
          m_run[ch] = 0;
        end else begin
          m_run[ch]++;
          if (m_run[ch] == D) begin
            m_deb[ch] = !m_deb[ch];
            m_run[ch] = 0;
            m_req[ch] = m_deb[ch];
          end
        end
      end
      m_ff2 = m_ff1;
      m_ff1 = in_now;
    end
  end

  // Monitor: per-cycle checks plus pulse scoreboard.
  int mon_rst_seen = 0;
  bit in_p[2];
  int wid[2];
  always @(negedge clk) begin
    logic cur;
    pulse_t e;
    if (rst_events != mon_rst_seen) begin
      mon_rst_seen = rst_events;
      in_p[0] = 1'b0;
      in_p[1] = 1'b0;
    end
    chk("busy", busy, (cyc < m_end));
    chk("conflict", conflict, m_conf);
    chk("s_and_r_exclusive", s & r, 1'b0);
    for (int ch = 0; ch < 2; ch++) begin
      cur = (ch == 1) ? r : s;
      if (cur) begin
        if (!in_p[ch]) begin
          in_p[ch] = 1'b1;
          wid[ch]  = 1;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse ch=%0d at cycle %0d: got a pulse, required none", ch, cyc);
          end else begin
            e = exp_q.pop_front();
            if (e.is_r != ch[0] || e.start != cyc) begin
              failures++;
              $display("FAIL pulse_match at cycle %0d: got is_r=%0d start=%0d, required is_r=%0d start=%0d",
                       cyc, ch, cyc, e.is_r, e.start);
            end
          end
        end else begin
          wid[ch]++;
        end
      end else if (in_p[ch]) begin
        in_p[ch] = 1'b0;
        checks++;
        if (wid[ch] != P) begin
          failures++;
          $display("FAIL pulse_width ch=%0d at cycle %0d: got %0d required %0d", ch, cyc, wid[ch], P);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int u;
    int n;
    // Reset held with buttons toggling.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_btn = i[0];
      rst_btn = ~i[1];
    end
    @(negedge clk);
    set_btn = 1'b0;
    rst_btn = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(10);

    // Clean set press, then release.
    set_btn = 1'b1; tick(20);
    set_btn = 1'b0; tick(15);

    // Glitch of D-1 cycles (discarded), then exactly D cycles (one pulse).
    set_btn = 1'b1; tick(D - 1);
    set_btn = 1'b0; tick(12);
    set_btn = 1'b1; tick(D);
    set_btn = 1'b0; tick(15);

    // Simultaneous press, then clear the conflict flag.
    set_btn = 1'b1; rst_btn = 1'b1; tick(12);
    set_btn = 1'b0; rst_btn = 1'b0; tick(10);
    conflict_clr = 1'b1; tick(1);
    conflict_clr = 1'b0; tick(5);

    // Reset request lands during the first cycle of the s pulse.
    set_btn = 1'b1; tick(1);
    rst_btn = 1'b1; tick(15);
    set_btn = 1'b0; rst_btn = 1'b0; tick(15);

    // Randomized button activity, including glitches and same-cycle edges.
    for (int i = 0; i < 3000; i++) begin
      u = $urandom_range(0, 31);
      if (u == 0) begin
        set_btn = ~set_btn;
        rst_btn = ~rst_btn;
      end else if (u < 4) begin
        set_btn = ~set_btn;
      end else if (u < 7) begin
        rst_btn = ~rst_btn;
      end
      conflict_clr = ($urandom_range(0, 15) == 0);
      tick(1);
    end
    set_btn = 1'b0; rst_btn = 1'b0; conflict_clr = 1'b0;
    tick(30);

    // Asynchronous reset in the middle of an s pulse.
    set_btn = 1'b1;
    n = 0;
    while (!s && n < 50) begin
      tick(1);
      n++;
    end
    chk("s_seen_before_async_reset", s, 1'b1);
    #2;
    rst_n   = 1'b0;
    set_btn = 1'b0;
    #1;
    chk("s_async_clear", s, 1'b0);
    chk("r_async_clear", r, 1'b0);
    chk("busy_async_clear", busy, 1'b0);
    tick(3);
    rst_n = 1'b1;
    tick(30);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_pulses: got %0d outstanding, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
